nv_ram_rwsp_fifo_ctrl: RTL and testbench

Valid/ready FIFO controller that sequences one 128x257 two-port RAM (`nv_ram_rwsp_128x257`: synchronous write; registered read address gated by `re`; registered output gated by `ore`) as a 129-entry elastic FIFO. It manages write/read pointers, occupancy and the two-stage stallable read pipeline. It hides the RAM's 2-cycle read latency and backpressure from the consumer. It sits between a producer and a consumer in a core datapath, alongside the RAM instance.

---
 rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv | 9 +
 rtl/nv_ram_rwsp_fifo_ctrl.sv | 93 +++++++++
 tb/tb_nv_ram_rwsp_fifo_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv
// Shared constants for the 128x257 RAM-backed FIFO controller and its wrapper.
package nv_ram_rwsp_fifo_ctrl_pkg;

    localparam int unsigned NV_RAM_FIFO_DEPTH = 128;
    localparam int unsigned NV_RAM_FIFO_AW    = 7;
    localparam int unsigned NV_RAM_FIFO_DW    = 257;
    localparam int unsigned NV_RAM_FIFO_CW    = 8;

endpackage

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// Valid/ready FIFO controller sequencing a two-port RAM with a 2-cycle stallable read
// pipeline (registered address, registered output) as a DEPTH+1 entry elastic FIFO.
module nv_ram_rwsp_fifo_ctrl
    import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = NV_RAM_FIFO_DEPTH,
    parameter int unsigned AW    = NV_RAM_FIFO_AW,
    parameter int unsigned DW    = NV_RAM_FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic [CW-1:0] pend_cnt;
    logic          s1_v;
    logic          s2_v;
    logic          flush;
    logic          wr_fire;
    logic          adv1;

    // ram_cnt keeps a slot live until its data is captured in dout_r, so a write
    // can never land on the address sitting in the RAM's read-address register.
    always_comb begin
        flush    = rst | clr;
        in_ready = !rst && (ram_cnt < FULL);
        wr_fire  = in_valid & in_ready & !clr;
        ram_ore  = !flush & s1_v & (!s2_v | out_ready);
        adv1     = !s1_v | ram_ore;
        ram_re   = !flush & adv1 & (pend_cnt != '0);
    end

    assign ram_we    = wr_fire;
    assign ram_wa    = wr_ptr;
    assign ram_di    = in_data;
    assign ram_ra    = rd_ptr;
    assign out_valid = s2_v;
    assign out_data  = ram_dout;
    assign count     = ram_cnt + CW'(s2_v);

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            pend_cnt <= '0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            ram_cnt  <= ram_cnt + CW'(wr_fire) - CW'(ram_ore);
            pend_cnt <= pend_cnt + CW'(wr_fire) - CW'(ram_re);

            if (ram_re) begin
                s1_v <= 1'b1;
            end else if (adv1) begin
                s1_v <= 1'b0;
            end

            if (ram_ore) begin
                s2_v <= 1'b1;
            end else if (out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// Bench for nv_ram_rwsp_fifo_ctrl with a behavioural RAM and a queue reference model.
module tb_nv_ram_rwsp_fifo_ctrl;
    import nv_ram_rwsp_fifo_ctrl_pkg::*;

    localparam int unsigned DEPTH = NV_RAM_FIFO_DEPTH;
    localparam int unsigned AW    = NV_RAM_FIFO_AW;
    localparam int unsigned DW    = NV_RAM_FIFO_DW;
    localparam int unsigned CW    = NV_RAM_FIFO_CW;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;

    nv_ram_rwsp_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
        .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore), .ram_dout(ram_dout)
    );

    // Two-port RAM: synchronous write, read address registered on re, output on ore.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_d;
    logic [DW-1:0] dout_r;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
        if (ram_ore) dout_r <= mem[ra_d];
    end
    assign ram_dout = dout_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] q[$];

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [DW-1:0] id;
        logic          e_ir;
        logic          e_ov;
        int            e_cnt;
        logic          e_we;
        logic          e_re;
        logic          e_ore;
        logic          chk_d;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t vt[5];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] v);
        return {v[0], {8{v ^ 32'h5A00_0000}}};
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] d;
        d = pat($urandom);
        d[128 +: 32] = $urandom;
        d[32 +: 32]  = $urandom;
        return d;
    endfunction

    // Reference: FIFO contents = accepted minus popped; clr empties it.
    task automatic model_check();
        chkn("count", int'(count), q.size());
        if (q.size() == 0) chk1("ov_empty", out_valid, 1'b0);
        if (out_valid && q.size() > 0) chkd("out_data", out_data, q[0]);
        if (q.size() < DEPTH) chk1("in_ready_room", in_ready, 1'b1);
        else if (q.size() == DEPTH + 1) chk1("in_ready_full", in_ready, 1'b0);
        chk1("ram_we", ram_we, in_valid & in_ready & !clr);
        if (clr) begin
            chk1("clr_re", ram_re, 1'b0);
            chk1("clr_ore", ram_ore, 1'b0);
        end
    endtask

    task automatic model_update();
        if (clr) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(in_data);
        end
    endtask

    task automatic run(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic iclr);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clr       = iclr;
        @(negedge clk);
        model_check();
        model_update();
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && q.size() > 0; c++) run(1'b0, '0, 1'b1, 1'b0);
        run(1'b0, '0, 1'b1, 1'b0);
        chkn("drain_done", int'(count), 0);
    endtask

    initial begin
        logic [DW-1:0] d0;
        int lat;
        int acc;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b1; in_data = pat(32'h1234);
        out_ready = 1'b1;
        d0 = {1'b1, {8{32'hDEAD_BEEF}}};

        vt[0] = '{1'b1, 1'b1, d0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
        vt[1] = '{1'b0, 1'b1, '0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, '0};
        vt[2] = '{1'b0, 1'b1, '0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, '0};
        vt[3] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, d0};
        vt[4] = '{1'b0, 1'b1, '0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chkn("rst_count", int'(count), 0);
        chk1("rst_we", ram_we, 1'b0);
        chk1("rst_re", ram_re, 1'b0);
        chk1("rst_ore", ram_ore, 1'b0);

        // Single write at latency 3, cycle by cycle.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rst       = 1'b0;
            in_valid  = vt[i].iv;
            in_data   = vt[i].id;
            out_ready = vt[i].ordy;
            @(negedge clk);
            chk1($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_ir);
            chk1($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            chkn($sformatf("vec%0d_count", i), int'(count), vt[i].e_cnt);
            chk1($sformatf("vec%0d_we", i), ram_we, vt[i].e_we);
            chk1($sformatf("vec%0d_re", i), ram_re, vt[i].e_re);
            chk1($sformatf("vec%0d_ore", i), ram_ore, vt[i].e_ore);
            if (vt[i].chk_d) chkd($sformatf("vec%0d_data", i), out_data, vt[i].e_d);
        end

        // Fill with the consumer stalled.
        for (int c = 0; c < 300 && q.size() < DEPTH + 1; c++) run(1'b1, pat(32'(q.size())), 1'b0, 1'b0);
        chkn("fill_accepted", q.size(), DEPTH + 1);
        run(1'b1, pat(32'd999), 1'b0, 1'b0);
        chk1("fill_in_ready", in_ready, 1'b0);
        chkn("fill_count", int'(count), DEPTH + 1);
        run(1'b0, '0, 1'b1, 1'b0);
        chk1("full_pop_in_ready", in_ready, 1'b0);
        chkd("full_first", out_data, pat(32'd0));
        run(1'b0, '0, 1'b1, 1'b0);
        chk1("after_pop_in_ready", in_ready, 1'b1);
        drain();

        // Both sides always ready: out_valid continuous from cycle 3.
        for (int c = 0; c < 200; c++) begin
            run(1'b1, pat(32'(c + 500)), 1'b1, 1'b0);
            if (c >= 3) chk1("no_gap", out_valid, 1'b1);
        end
        drain();

        // Random streaming of 1000 beats.
        acc = 0;
        for (int c = 0; c < 8000 && acc < 1000; c++) begin
            run(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)), 1'b0);
            if (in_valid && in_ready) acc++;
        end
        chkn("random_beats", acc, 1000);
        drain();

        // Pointer wrap with occupancy held at 5.
        for (int c = 0; c < 5; c++) run(1'b1, pat(32'(c + 2000)), 1'b0, 1'b0);
        for (int c = 0; c < 300; c++) begin
            run(1'b1, pat(32'(c + 3000)), 1'b1, 1'b0);
            chkn("wrap_occ", int'(count), 5);
            chk1("wrap_ov", out_valid, 1'b1);
        end
        drain();

        // Flush with 50 entries and both pipeline stages occupied.
        for (int c = 0; c < 50; c++) run(1'b1, pat(32'(c + 4000)), 1'b0, 1'b0);
        repeat (3) run(1'b0, '0, 1'b0, 1'b0);
        chk1("pre_clr_ov", out_valid, 1'b1);
        run(1'b1, pat(32'd7777), 1'b1, 1'b1);
        run(1'b0, '0, 1'b1, 1'b0);
        chk1("clr_out_valid", out_valid, 1'b0);
        chkn("clr_count", int'(count), 0);
        run(1'b1, d0 ^ pat(32'd42), 1'b1, 1'b0);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            run(1'b0, '0, 1'b1, 1'b0);
            if (out_valid) lat = c;
        end
        chkn("clr_latency", lat, 3);
        drain();

        // Reset mid-stream with out_ready toggling.
        for (int c = 0; c < 30; c++) run(1'($urandom_range(0, 1)), rnd(), 1'(c % 2), 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b1; in_valid = 1'b1; in_data = rnd(); out_ready = 1'(k);
            @(negedge clk);
            chk1("midrst_in_ready", in_ready, 1'b0);
            chk1("midrst_we", ram_we, 1'b0);
            chk1("midrst_re", ram_re, 1'b0);
            chk1("midrst_ore", ram_ore, 1'b0);
            if (k == 1) begin
                chk1("midrst_out_valid", out_valid, 1'b0);
                chkn("midrst_count", int'(count), 0);
            end
        end
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk1("postrst_in_ready", in_ready, 1'b1);
        chk1("postrst_out_valid", out_valid, 1'b0);
        chkn("postrst_count", int'(count), 0);
        for (int c = 0; c < 10; c++) run(1'b1, pat(32'(c + 6000)), 1'b1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
